// File: rtl/spike_count_pool.sv
// spike_count_pool: windowed MN pool spike counter with timestamped event FIFO
module spike_count_pool #(
    parameter int NN      = 8,
    parameter int FIFO_AW = 6
) (
    input  logic               rawclk,
    input  logic               reset_sim,
    input  logic               spike_in,
    input  logic               slot_valid,
    input  logic [NN:0]        neuron_index,
    input  logic [15:0]        window_sweeps,
    input  logic               rd_en,
    output logic [31:0]        spike_count_out,
    output logic               count_valid,
    output logic [31:0]        event_data,
    output logic               event_empty,
    output logic               event_full,
    output logic [FIFO_AW:0]   event_level,
    output logic               event_overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_nx;
    logic [15:0]        ts, sweep_cnt, win_len, win_eff;
    logic [31:0]        acc, acc_nx;
    logic               hit, sweep_end, win_close, wr, rd;

    // slot qualification, window close detection and FIFO handshake
    always_comb begin
        hit       = slot_valid && spike_in;
        sweep_end = slot_valid && (neuron_index == '1);
        win_close = sweep_end && (sweep_cnt + 16'd1 == win_len);
        win_eff   = (window_sweeps == 16'd0) ? 16'd1 : window_sweeps;
        acc_nx    = (hit && acc != 32'hFFFF_FFFF) ? acc + 32'd1 : acc;
        wr        = hit && !event_full;
        rd        = rd_en && !event_empty;
        level_nx  = event_level + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(rd);
    end

    assign event_data = event_empty ? 32'd0 : mem[rd_ptr];

    // event storage; pointers gate visibility so the array needs no reset
    always_ff @(posedge rawclk) begin
        if (!reset_sim && wr)
            mem[wr_ptr] <= {ts, {(15-NN){1'b0}}, neuron_index};
    end

    // counting, timestamp and FIFO bookkeeping
    always_ff @(posedge rawclk) begin
        if (reset_sim) begin
            ts              <= '0;
            sweep_cnt       <= '0;
            win_len         <= win_eff;
            acc             <= '0;
            spike_count_out <= '0;
            count_valid     <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            event_level     <= '0;
            event_empty     <= 1'b1;
            event_full      <= 1'b0;
            event_overflow  <= 1'b0;
        end else begin
            ts              <= sweep_end ? ts + 16'd1 : ts;
            sweep_cnt       <= win_close ? 16'd0 : sweep_end ? sweep_cnt + 16'd1 : sweep_cnt;
            win_len         <= win_close ? win_eff : win_len;
            acc             <= win_close ? 32'd0 : acc_nx;
            spike_count_out <= win_close ? acc_nx : spike_count_out;
            count_valid     <= win_close;
            wr_ptr          <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr          <= rd ? rd_ptr + 1'b1 : rd_ptr;
            event_level     <= level_nx;
            event_empty     <= (level_nx == '0);
            event_full      <= (level_nx == (FIFO_AW+1)'(DEPTH));
            event_overflow  <= event_overflow || (hit && event_full);
        end
    end
endmodule

// File: tb/tb_spike_count_pool.sv
// tb_spike_count_pool: randomized and directed check of spike_count_pool against a queue model
module tb_spike_count_pool;
    localparam int NN = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int LAST = 511;

    logic        rawclk = 0, reset_sim = 0, spike_in = 0, slot_valid = 0, rd_en = 0;
    logic [8:0]  neuron_index = '0;
    logic [15:0] window_sweeps = 16'd1;
    logic [31:0] spike_count_out, event_data;
    logic        count_valid, event_empty, event_full, event_overflow;
    logic [4:0]  event_level;

    int n_cmp = 0, n_bad = 0;

    bit [31:0] q[$];
    bit [15:0] m_ts;
    int        m_sw, m_win;
    longint    m_acc;
    bit [31:0] m_out;
    bit        m_cv, m_ovf;

    spike_count_pool #(.NN(NN), .FIFO_AW(AW)) dut (
        .rawclk(rawclk), .reset_sim(reset_sim), .spike_in(spike_in), .slot_valid(slot_valid),
        .neuron_index(neuron_index), .window_sweeps(window_sweeps), .rd_en(rd_en),
        .spike_count_out(spike_count_out), .count_valid(count_valid), .event_data(event_data),
        .event_empty(event_empty), .event_full(event_full), .event_level(event_level),
        .event_overflow(event_overflow)
    );

    always #5 rawclk = ~rawclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count", spike_count_out, m_out);
        chk("cvalid", 32'(count_valid), 32'(m_cv));
        chk("level", 32'(event_level), q.size());
        chk("empty", 32'(event_empty), 32'(q.size() == 0));
        chk("full", 32'(event_full), 32'(q.size() == DEPTH));
        chk("data", event_data, q.size() > 0 ? q[0] : 32'd0);
        chk("ovf", 32'(event_overflow), 32'(m_ovf));
    endtask

    task automatic do_reset(input int cycles);
        reset_sim = 1;
        for (int i = 0; i < cycles; i++) begin
            slot_valid = 1'b1;
            spike_in = 1'b1;
            neuron_index = 9'($urandom_range(0, LAST));
            rd_en = 1'($urandom);
            @(posedge rawclk);
            q.delete();
            m_ts = 0; m_sw = 0; m_acc = 0; m_out = 0; m_cv = 0; m_ovf = 0;
            m_win = (window_sweeps == 0) ? 1 : int'(window_sweeps);
            #1;
            check_all();
        end
        reset_sim = 0;
        slot_valid = 0; spike_in = 0; rd_en = 0;
    endtask

    task automatic step(input bit sv, input bit spk, input int idx, input bit rdv);
        bit hit;
        bit push;
        slot_valid = sv; spike_in = spk; neuron_index = 9'(idx); rd_en = rdv;
        @(posedge rawclk);
        hit = sv && spk;
        push = hit && q.size() < DEPTH;
        if (hit && !push) m_ovf = 1;
        if (rdv && q.size() > 0) void'(q.pop_front());
        if (push) q.push_back({m_ts, 7'd0, 9'(idx)});
        if (hit && m_acc < 64'hFFFF_FFFF) m_acc++;
        m_cv = 0;
        if (sv && idx == LAST) begin
            m_sw++;
            if (m_sw == m_win) begin
                m_out = 32'(m_acc);
                m_cv = 1;
                m_acc = 0;
                m_sw = 0;
                m_win = (window_sweeps == 0) ? 1 : int'(window_sweeps);
            end
            m_ts++;
        end
        #1;
        check_all();
    endtask

    initial begin
        bit [31:0] exp4 [4];
        exp4 = '{32'h0000_0005, 32'h0000_01FF, 32'h0001_0005, 32'h0001_01FF};

        window_sweeps = 16'd2;
        do_reset(3);

        for (int s = 0; s < 2; s++) begin
            step(1, 1, 5, 0);
            step(1, 1, LAST, 0);
        end
        chk("win2_pulse", 32'(count_valid), 32'd1);
        chk("win2_count", spike_count_out, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("win2_evt", event_data, exp4[i]);
            step(0, 0, 0, 1);
        end
        chk("win2_drained", 32'(event_empty), 32'd1);

        window_sweeps = 16'd0;
        do_reset(1);
        for (int s = 0; s < 3; s++) begin
            step(1, 1, 1, 1);
            step(0, 1, 2, 1);
            step(1, 1, 2, 1);
            step(1, 1, LAST, 1);
            chk("ws0_count", spike_count_out, 32'd3);
            chk("ws0_pulse", 32'(count_valid), 32'd1);
        end

        window_sweeps = 16'd1;
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1, 1, i, 0);
        chk("ovf_full", 32'(event_full), 32'd1);
        chk("ovf_level", 32'(event_level), 32'd16);
        chk("ovf_flag", 32'(event_overflow), 32'd1);
        chk("ovf_head", event_data, 32'd0);
        step(1, 0, LAST, 0);
        chk("ovf_count", spike_count_out, 32'd20);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_order", event_data, 32'(i));
            step(0, 0, 0, 1);
        end

        do_reset(1);
        for (int i = 0; i < 5; i++) step(1, 1, 10 + i, 0);
        step(1, 1, 3, 1);
        chk("rw_level", 32'(event_level), 32'd5);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        chk("under_level", 32'(event_level), 32'd0);
        chk("under_empty", 32'(event_empty), 32'd1);

        window_sweeps = 16'd5;
        do_reset(1);
        for (int i = 0; i < 7; i++) step(1, 1, 20 + i, 0);
        window_sweeps = 16'd1;
        do_reset(1);
        step(1, 1, 4, 0);
        step(1, 1, LAST, 0);
        chk("mid_count", spike_count_out, 32'd2);
        chk("mid_ts0", event_data, 32'h0000_0004);

        window_sweeps = 16'd2;
        do_reset(2);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) window_sweeps = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) do_reset(1);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0) ? LAST : int'($urandom_range(0, LAST)),
                 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
